// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, NOP, ID/EX control word
// and source-register usage helpers.
package id_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // AluSel is {funct7[5], funct3} for ALU ops; 4'hF passes operand B (LUI)
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_PASS = 4'hF;

  typedef struct packed {
    logic [3:0] alu_sel;
    logic       b_sel;
    logic       a_sel;
    logic       mem_rw;
    logic       br_un;
    logic       reg_wen;
    logic [1:0] wb_sel;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic logic uses_rs1(input logic [31:0] inst);
    return !(inst[6:0] == OPC_LUI || inst[6:0] == OPC_AUIPC || inst[6:0] == OPC_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [31:0] inst);
    return inst[6:0] == OPC_OP || inst[6:0] == OPC_STORE || inst[6:0] == OPC_BRANCH;
  endfunction

  function automatic logic is_load(input logic [31:0] inst);
    return inst[6:0] == OPC_LOAD;
  endfunction

endpackage

// File: rtl/ctrl_unit.sv
// RV32I control decoder producing the ID/EX control word.
module ctrl_unit
  import id_pkg::*;
(
  input  logic [31:0]       inst_i,
  output logic [CTRL_W-1:0] ctrl_o
);
  ctrl_t w_c;
  logic [2:0] w_f3;

  assign w_f3   = inst_i[14:12];
  assign ctrl_o = w_c;

  always_comb begin
    w_c = '0;
    case (inst_i[6:0])
      OPC_OP:     begin w_c.alu_sel = {inst_i[30], w_f3}; w_c.reg_wen = 1'b1; w_c.wb_sel = WB_ALU; end
      // only SRAI/SRLI use funct7[5]; for other OP-IMM it is immediate bits
      OPC_OPIMM:  begin w_c.alu_sel = {(w_f3 == 3'b101) & inst_i[30], w_f3}; w_c.b_sel = 1'b1;
                        w_c.reg_wen = 1'b1; w_c.wb_sel = WB_ALU; end
      OPC_LOAD:   begin w_c.alu_sel = ALU_ADD; w_c.b_sel = 1'b1; w_c.reg_wen = 1'b1; w_c.wb_sel = WB_MEM; end
      OPC_STORE:  begin w_c.alu_sel = ALU_ADD; w_c.b_sel = 1'b1; w_c.mem_rw = 1'b1; end
      OPC_BRANCH: begin w_c.a_sel = 1'b1; w_c.b_sel = 1'b1; w_c.br_un = w_f3[1]; end
      OPC_LUI:    begin w_c.alu_sel = ALU_PASS; w_c.b_sel = 1'b1; w_c.reg_wen = 1'b1; w_c.wb_sel = WB_ALU; end
      OPC_AUIPC:  begin w_c.a_sel = 1'b1; w_c.b_sel = 1'b1; w_c.reg_wen = 1'b1; w_c.wb_sel = WB_ALU; end
      OPC_JAL:    begin w_c.a_sel = 1'b1; w_c.b_sel = 1'b1; w_c.reg_wen = 1'b1; w_c.wb_sel = WB_PC4; end
      OPC_JALR:   begin w_c.b_sel = 1'b1; w_c.reg_wen = 1'b1; w_c.wb_sel = WB_PC4; end
      default: ;
    endcase
  end
endmodule

// File: rtl/id_hazard_unit.sv
// Combinational ID/EX sequencing: flush > downstream hold > hazard bubble > normal capture.
module id_hazard_unit #(
  parameter int RW = 5
) (
  input  logic          valid_d_i,
  input  logic          use_rs1_d_i,
  input  logic          use_rs2_d_i,
  input  logic [RW-1:0] rs1_d_i,
  input  logic [RW-1:0] rs2_d_i,
  input  logic          valid_ex_i,
  input  logic          load_ex_i,
  input  logic [RW-1:0] rsW_ex_i,
  input  logic          wb_conflict_i,
  input  logic          stall_ex_i,
  input  logic          flush_i,
  output logic          capture_en_o,
  output logic          insert_bubble_o,
  output logic          stall_d_o
);
  logic w_load_use;
  logic w_hazard;

  assign w_load_use = valid_ex_i && load_ex_i && (rsW_ex_i != '0) && valid_d_i &&
                      ((use_rs1_d_i && rs1_d_i == rsW_ex_i) || (use_rs2_d_i && rs2_d_i == rsW_ex_i));
  assign w_hazard   = w_load_use || wb_conflict_i;

  always_comb begin
    capture_en_o    = 1'b1;
    insert_bubble_o = !valid_d_i;
    stall_d_o       = 1'b0;
    if (flush_i) begin
      insert_bubble_o = 1'b1;
    end else if (stall_ex_i) begin
      capture_en_o = 1'b0;
      stall_d_o    = 1'b1;
    end else if (w_hazard) begin
      insert_bubble_o = 1'b1;
      stall_d_o       = 1'b1;
    end
  end
endmodule

// File: rtl/imm_gen.sv
// RV32I immediate generator: selects the I/S/B/U/J format from the opcode.
module imm_gen
  import id_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic [31:0] imm_o
);
  always_comb begin
    imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
    case (inst_i[6:0])
      OPC_STORE:          imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      OPC_BRANCH:         imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm_o = {inst_i[31:12], 12'b0};
      OPC_JAL:            imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      default: ;
    endcase
  end
endmodule

// File: rtl/id_stage_hz.sv
// Decode stage with register file, hazard unit and valid/hold/flush ID/EX register.
// Optional macro ID_WB_BYPASS_EN: forward same-cycle writeback into the read path.
module id_stage_hz
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RW   = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_d_i,
  input  logic [31:0]     inst_d_i,
  input  logic [XLEN-1:0] pc_d_i,
  input  logic [XLEN-1:0] pc4_d_i,
  input  logic [XLEN-1:0] data_wb_i,
  input  logic [RW-1:0]   rsW_i,
  input  logic            RegWEn_i,
  input  logic            stall_ex_i,
  input  logic            flush_i,
  output logic            stall_d_o,
  output logic            valid_ex_o,
  output logic [XLEN-1:0] rs1_ex_o,
  output logic [XLEN-1:0] rs2_ex_o,
  output logic [XLEN-1:0] imm_ex_o,
  output logic [XLEN-1:0] pc_ex_o,
  output logic [XLEN-1:0] pc4_ex_o,
  output logic [RW-1:0]   rs1_addr_ex_o,
  output logic [RW-1:0]   rs2_addr_ex_o,
  output logic [RW-1:0]   rsW_ex_o,
  output logic [3:0]      AluSel_ex_o,
  output logic            BSel_ex_o,
  output logic            ASel_ex_o,
  output logic            MemRW_ex_o,
  output logic            BrUn_ex_o,
  output logic            RegWEn_ex_o,
  output logic [1:0]      WBSel_ex_o,
  output logic [31:0]     inst_ex_o
);
  logic [XLEN-1:0] r_regs [NREG];
  logic [RW-1:0]   w_rs1_idx, w_rs2_idx, w_rd_idx;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val, w_imm_x;
  logic [31:0]     w_imm32;
  logic [CTRL_W-1:0] w_ctrl;
  logic            w_wb_conflict, w_capture, w_bubble;

  logic            r_valid;
  logic [XLEN-1:0] r_rs1, r_rs2, r_imm, r_pc, r_pc4;
  logic [RW-1:0]   r_rs1_addr, r_rs2_addr, r_rsw;
  ctrl_t           r_ctrl;
  logic [31:0]     r_inst;

  assign w_rs1_idx = inst_d_i[15 +: RW];
  assign w_rs2_idx = inst_d_i[20 +: RW];
  assign w_rd_idx  = inst_d_i[7 +: RW];

  // entry 0 is reset-only, so x0 reads 0 without a read-side mux
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_rf
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
          r_regs[gi] <= '0;
        else if (gi != 0 && RegWEn_i && rsW_i == RW'(gi))
          r_regs[gi] <= data_wb_i;
      end
    end
  endgenerate

`ifdef ID_WB_BYPASS_EN
  assign w_rs1_val = (RegWEn_i && rsW_i != '0 && rsW_i == w_rs1_idx) ? data_wb_i : r_regs[w_rs1_idx];
  assign w_rs2_val = (RegWEn_i && rsW_i != '0 && rsW_i == w_rs2_idx) ? data_wb_i : r_regs[w_rs2_idx];
  assign w_wb_conflict = 1'b0;
`else
  assign w_rs1_val = r_regs[w_rs1_idx];
  assign w_rs2_val = r_regs[w_rs2_idx];
  assign w_wb_conflict = valid_d_i && RegWEn_i && rsW_i != '0 &&
                         ((uses_rs1(inst_d_i) && rsW_i == w_rs1_idx) ||
                          (uses_rs2(inst_d_i) && rsW_i == w_rs2_idx));
`endif

  imm_gen u_imm (.inst_i(inst_d_i), .imm_o(w_imm32));
  ctrl_unit u_ctrl (.inst_i(inst_d_i), .ctrl_o(w_ctrl));
  assign w_imm_x = XLEN'($signed(w_imm32));

  id_hazard_unit #(.RW(RW)) u_hz (
    .valid_d_i      (valid_d_i),
    .use_rs1_d_i    (uses_rs1(inst_d_i)),
    .use_rs2_d_i    (uses_rs2(inst_d_i)),
    .rs1_d_i        (w_rs1_idx),
    .rs2_d_i        (w_rs2_idx),
    .valid_ex_i     (r_valid),
    .load_ex_i      (is_load(r_inst)),
    .rsW_ex_i       (r_rsw),
    .wb_conflict_i  (w_wb_conflict),
    .stall_ex_i     (stall_ex_i),
    .flush_i        (flush_i),
    .capture_en_o   (w_capture),
    .insert_bubble_o(w_bubble),
    .stall_d_o      (stall_d_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || (w_capture && w_bubble)) begin
      r_valid <= 1'b0;  r_rs1 <= '0;  r_rs2 <= '0;  r_imm <= '0;
      r_pc <= '0;  r_pc4 <= '0;  r_rs1_addr <= '0;  r_rs2_addr <= '0;
      r_rsw <= '0;  r_ctrl <= '0;  r_inst <= NOP_INST;
    end else if (w_capture) begin
      r_valid <= 1'b1;  r_rs1 <= w_rs1_val;  r_rs2 <= w_rs2_val;  r_imm <= w_imm_x;
      r_pc <= pc_d_i;  r_pc4 <= pc4_d_i;  r_rs1_addr <= w_rs1_idx;  r_rs2_addr <= w_rs2_idx;
      r_rsw <= w_rd_idx;  r_ctrl <= ctrl_t'(w_ctrl);  r_inst <= inst_d_i;
    end
  end

  assign valid_ex_o    = r_valid;
  assign rs1_ex_o      = r_rs1;
  assign rs2_ex_o      = r_rs2;
  assign imm_ex_o      = r_imm;
  assign pc_ex_o       = r_pc;
  assign pc4_ex_o      = r_pc4;
  assign rs1_addr_ex_o = r_rs1_addr;
  assign rs2_addr_ex_o = r_rs2_addr;
  assign rsW_ex_o      = r_rsw;
  assign AluSel_ex_o   = r_ctrl.alu_sel;
  assign BSel_ex_o     = r_ctrl.b_sel;
  assign ASel_ex_o     = r_ctrl.a_sel;
  assign MemRW_ex_o    = r_ctrl.mem_rw;
  assign BrUn_ex_o     = r_ctrl.br_un;
  assign RegWEn_ex_o   = r_ctrl.reg_wen;
  assign WBSel_ex_o    = r_ctrl.wb_sel;
  assign inst_ex_o     = r_inst;
endmodule

// File: tb/tb_id_stage_hz.sv
// Directed bench for id_stage_hz: reset, load-use, hold, flush, WB conflict/bypass, x0.
module tb_id_stage_hz;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  localparam logic [31:0] I_LW   = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_ADD  = 32'h00728333; // add  x6,x5,x7
  localparam logic [31:0] I_LUI  = 32'h000012B7; // lui  x5,1
  localparam logic [31:0] I_ADDI = 32'h00700193; // addi x3,x0,7
  localparam logic [31:0] I_SUB  = 32'h40708233; // sub  x4,x1,x7
  localparam logic [31:0] I_ADD9 = 32'h00048133; // add  x2,x9,x0

  logic clk, rst, valid_d, regwen, stall_ex, flush;
  logic [31:0] inst_d;
  logic [XLEN-1:0] pc_d, pc4_d, data_wb;
  logic [RW-1:0] rsw;
  logic stall_d, valid_ex;
  logic [XLEN-1:0] rs1_ex, rs2_ex, imm_ex, pc_ex, pc4_ex;
  logic [RW-1:0] rs1_addr_ex, rs2_addr_ex, rsw_ex;
  logic [3:0] alusel_ex;
  logic bsel_ex, asel_ex, memrw_ex, brun_ex, regwen_ex;
  logic [1:0] wbsel_ex;
  logic [31:0] inst_ex;

  int n_chk = 0;
  int n_fail = 0;

  id_stage_hz #(.XLEN(XLEN), .NREG(32)) dut (
    .clk_i(clk), .rst_i(rst), .valid_d_i(valid_d), .inst_d_i(inst_d),
    .pc_d_i(pc_d), .pc4_d_i(pc4_d), .data_wb_i(data_wb), .rsW_i(rsw),
    .RegWEn_i(regwen), .stall_ex_i(stall_ex), .flush_i(flush),
    .stall_d_o(stall_d), .valid_ex_o(valid_ex),
    .rs1_ex_o(rs1_ex), .rs2_ex_o(rs2_ex), .imm_ex_o(imm_ex),
    .pc_ex_o(pc_ex), .pc4_ex_o(pc4_ex),
    .rs1_addr_ex_o(rs1_addr_ex), .rs2_addr_ex_o(rs2_addr_ex), .rsW_ex_o(rsw_ex),
    .AluSel_ex_o(alusel_ex), .BSel_ex_o(bsel_ex), .ASel_ex_o(asel_ex),
    .MemRW_ex_o(memrw_ex), .BrUn_ex_o(brun_ex), .RegWEn_ex_o(regwen_ex),
    .WBSel_ex_o(wbsel_ex), .inst_ex_o(inst_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else
      $display("ok   %s: %h", tag, got);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [31:0] inst, input logic [31:0] pc);
    valid_d = 1'b1;
    inst_d  = inst;
    pc_d    = pc;
    pc4_d   = pc + 32'd4;
  endtask

  task automatic wb_write(input logic [RW-1:0] idx, input logic [31:0] val);
    regwen  = 1'b1;
    rsw     = idx;
    data_wb = val;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; valid_d = 1'b0; inst_d = 32'h13; pc_d = '0; pc4_d = '0;
    data_wb = '0; rsw = '0; regwen = 1'b0; stall_ex = 1'b0; flush = 1'b0;
    step(); step();
    chk("rst_inst", inst_ex, 32'h00000013);
    chk("rst_valid", valid_ex, 0);
    chk("rst_stall", stall_d, 0);
    chk("rst_rsw", rsw_ex, 0);
    rst = 1'b0;

    // preload x1=100, x7=7 and attempt to write x0
    wb_write(5'd1, 32'd100);
    wb_write(5'd7, 32'd7);
    wb_write(5'd0, 32'hFFFF);
    regwen = 1'b0;
    chk("idle_valid", valid_ex, 0);
    chk("idle_inst", inst_ex, 32'h13);

    // load-use: exactly one bubble, then the add with rs1_addr=5
    set_id(I_LW, 32'h100);
    #1 chk("lw_nostall", stall_d, 0);
    step();
    chk("lw_valid", valid_ex, 1);
    chk("lw_rs1", rs1_ex, 100);
    chk("lw_rsw", rsw_ex, 5);
    chk("lw_wbsel", wbsel_ex, 0);
    chk("lw_pc4", pc4_ex, 32'h104);
    set_id(I_ADD, 32'h104);
    #1 chk("lu_stall", stall_d, 1);
    step();
    chk("lu_bub_valid", valid_ex, 0);
    chk("lu_bub_inst", inst_ex, 32'h13);
    chk("lu_bub_wen", regwen_ex, 0);
    chk("lu_clear", stall_d, 0);
    step();
    chk("add_valid", valid_ex, 1);
    chk("add_rs1a", rs1_addr_ex, 5);
    chk("add_rs2", rs2_ex, 7);
    chk("add_rsw", rsw_ex, 6);
    chk("add_bsel", bsel_ex, 0);

    // lui does not read rs1: no stall after a load to x5
    set_id(I_LW, 32'h200);
    step();
    set_id(I_LUI, 32'h204);
    #1 chk("lui_nostall", stall_d, 0);
    step();
    chk("lui_imm", imm_ex, 32'h1000);
    chk("lui_alu", alusel_ex, 4'hF);
    chk("lui_valid", valid_ex, 1);

    // hold sub in EX for 3 cycles
    set_id(I_SUB, 32'h300);
    step();
    chk("sub_alu", alusel_ex, 4'h8);
    chk("sub_rs1", rs1_ex, 100);
    set_id(I_ADDI, 32'h304);
    stall_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_stall", stall_d, 1);
      step();
      chk("hold_inst", inst_ex, I_SUB);
      chk("hold_rs2", rs2_ex, 7);
      chk("hold_valid", valid_ex, 1);
    end

    // flush beats the downstream hold
    flush = 1'b1;
    #1 chk("flush_stall", stall_d, 0);
    step();
    chk("flush_valid", valid_ex, 0);
    chk("flush_wen", regwen_ex, 0);
    chk("flush_inst", inst_ex, 32'h13);
    flush = 1'b0; stall_ex = 1'b0;

    // same-cycle writeback of a source register
    set_id(I_ADD9, 32'h400);
    regwen = 1'b1; rsw = 5'd9; data_wb = 32'hDEADBEEF;
`ifdef ID_WB_BYPASS_EN
    #1 chk("wb_nostall", stall_d, 0);
    step();
    regwen = 1'b0;
`else
    #1 chk("wb_stall", stall_d, 1);
    step();
    chk("wb_bub_valid", valid_ex, 0);
    regwen = 1'b0;
    #1 chk("wb_clear", stall_d, 0);
    step();
`endif
    chk("wb_rs1", rs1_ex, 32'hDEADBEEF);
    chk("wb_valid", valid_ex, 1);
    chk("wb_rsw", rsw_ex, 2);

    // x0 must still read zero after the earlier write attempt
    set_id(I_ADDI, 32'h500);
    step();
    chk("x0_rs1", rs1_ex, 0);
    chk("addi_imm", imm_ex, 7);
    chk("addi_wbsel", wbsel_ex, 1);

    // reset asserted mid-stall clears EX immediately
    set_id(I_LW, 32'h600);
    step();
    set_id(I_ADD, 32'h604);
    #1 chk("pre_rst_stall", stall_d, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", valid_ex, 0);
    chk("mid_rst_inst", inst_ex, 32'h13);
    chk("mid_rst_stall", stall_d, 0);
    chk("mid_rst_pc", pc_ex, 0);
    #1 rst = 1'b0;
    valid_d = 1'b0;
    step();
    chk("post_rst_valid", valid_ex, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
